// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU request scheduler.
//   - DW_DEF / RW_DEF : default operand and result widths
//   - OP_*            : 3-bit opcode encodings
//   - state_t         : scheduler FSM states
package alu_pkg;

  localparam int DW_DEF = 4;
  localparam int RW_DEF = 8;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: restoring unsigned divider, one quotient bit per cycle, MSB
// first. The first bit is resolved on the start edge itself, so done is high
// exactly DW cycles after the start cycle, with quotient valid while done=1.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle pulse; dividend/divisor sampled on this edge
//   dividend  : DW-bit unsigned dividend
//   divisor   : DW-bit unsigned divisor (caller guarantees nonzero)
//   busy      : iterations still outstanding
//   done      : one-cycle pulse, quotient valid
//   quotient  : DW-bit quotient
module alu_div_iter
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient
);

  localparam int CW = $clog2(DW) + 1;

  logic [DW-1:0] rem;
  logic [DW-1:0] q;
  logic [DW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic [DW-1:0] src_rem;
  logic [DW-1:0] src_q;
  logic [DW-1:0] src_dvs;
  logic [DW:0]   shifted;
  logic [DW:0]   diff;
  logic [DW-1:0] rem_step;
  logic [DW-1:0] q_step;

  // One restoring step. The partial remainder stays below the divisor, so
  // shifted < 2*divisor and a DW+1 bit difference carries a valid sign bit.
  // q doubles as the dividend shift register: its MSB is the next dividend
  // bit and quotient bits enter at the LSB.
  always_comb begin
    src_rem  = start ? '0 : rem;
    src_q    = start ? dividend : q;
    src_dvs  = start ? divisor : dvs;
    shifted  = {src_rem, src_q[DW-1]};
    diff     = shifted - {1'b0, src_dvs};
    rem_step = shifted[DW-1:0];
    q_step   = {src_q[DW-2:0], 1'b0};
    if (!diff[DW]) begin
      rem_step = diff[DW-1:0];
      q_step   = {src_q[DW-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      q    <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= rem_step;
      q    <= q_step;
      dvs  <= divisor;
      cnt  <= CW'(DW - 1);
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      rem <= rem_step;
      q   <= q_step;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = q;

endmodule

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: shares one 4-bit ALU between two requesters.
// A round-robin arbiter accepts one command at a time; single-cycle ops run in
// EXEC, divide runs through alu_div_iter, and the tagged result is presented
// on the response channel until consumed.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b (N=0,1)  : command channels
//   rsp_valid/ready                  : response handshake
//   rsp_id                           : requester that issued the command
//   rsp_result                       : RW-bit result
//   rsp_err                          : divide-by-zero or illegal opcode
//
// Handshake semantics (both channels): a transfer happens on the rising edge
// where valid and ready are both 1. A producer keeps valid (and its payload)
// until the transfer; here the response side holds rsp_valid and all rsp_*
// fields stable until rsp_ready. reqN_ready is a combinational function of the
// two valids, the grant pointer and the FSM state only, never of rsp_ready.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [2:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [2:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [RW-1:0] rsp_result,
  output logic          rsp_err
);

  state_t state;
  state_t state_next;

  // grant_ptr holds the id granted last; the other one wins a contention.
  logic          grant_ptr;
  logic          cap_id;
  logic [2:0]    cap_op;
  logic [DW-1:0] cap_a;
  logic [DW-1:0] cap_b;

  logic          gnt0;
  logic          gnt1;
  logic          accept_en;
  logic          hs;
  logic          hs_id;
  logic [2:0]    sel_op;
  logic [DW-1:0] sel_a;
  logic [DW-1:0] sel_b;
  logic          div_start;
  logic          div_busy;
  logic          div_done;
  logic [DW-1:0] div_q;

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;
  logic [RW-1:0] alu_res;
  logic          alu_err;

  // Arbiter and accept logic.
  always_comb begin
    gnt0       = req0_valid & (~req1_valid | grant_ptr);
    gnt1       = req1_valid & (~req0_valid | ~grant_ptr);
    // The divider is always idle in IDLE; the busy term only guards against
    // overlapping a new start with a running division.
    accept_en  = (state == ST_IDLE) & ~rst & ~div_busy;
    req0_ready = accept_en & gnt0;
    req1_ready = accept_en & gnt1;
    hs         = req0_ready | req1_ready;
    hs_id      = req1_ready;
    sel_op     = hs_id ? req1_op : req0_op;
    sel_a      = hs_id ? req1_a  : req0_a;
    sel_b      = hs_id ? req1_b  : req0_b;
    // Divide-by-zero bypasses the divider and is flagged in EXEC.
    div_start  = hs & (sel_op == OP_DIV) & (sel_b != '0);
  end

  // FSM next state and response valid.
  always_comb begin
    state_next = state;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          state_next = div_start ? ST_DIV : ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_DIV: begin
        if (div_done) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Single-cycle datapath on the captured command. OP_DIV only reaches EXEC
  // with a zero divisor, so it is an error here.
  always_comb begin
    a_ext   = RW'(cap_a);
    b_ext   = RW'(cap_b);
    alu_res = '0;
    alu_err = 1'b0;
    case (cap_op)
      OP_AND:  alu_res = a_ext & b_ext;
      OP_OR:   alu_res = a_ext | b_ext;
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MUL:  alu_res = a_ext * b_ext;
      OP_DIV:  alu_err = 1'b1;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_ptr  <= 1'b1;
      cap_id     <= 1'b0;
      cap_op     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (hs) begin
        grant_ptr <= hs_id;
        cap_id    <= hs_id;
        cap_op    <= sel_op;
        cap_a     <= sel_a;
        cap_b     <= sel_b;
      end
      if (state == ST_EXEC) begin
        rsp_id     <= cap_id;
        rsp_result <= alu_res;
        rsp_err    <= alu_err;
      end
      if ((state == ST_DIV) && div_done) begin
        rsp_id     <= cap_id;
        rsp_result <= RW'(div_q);
        rsp_err    <= 1'b0;
      end
    end
  end

  alu_div_iter #(
    .DW(DW)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (sel_a),
    .divisor  (sel_b),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_q)
  );

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb_alu_req_scheduler: directed bench for alu_req_scheduler.
// Clock/reset, driver tasks, response scoreboard, final report.
module tb_alu_req_scheduler;

  localparam logic [2:0] T_AND = 3'b000;
  localparam logic [2:0] T_OR  = 3'b001;
  localparam logic [2:0] T_ADD = 3'b010;
  localparam logic [2:0] T_SUB = 3'b011;
  localparam logic [2:0] T_MUL = 3'b100;
  localparam logic [2:0] T_DIV = 3'b101;
  localparam logic [2:0] T_ILL = 3'b111;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic       req0_ready;
  logic [2:0] req0_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [2:0] req1_op;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_err;

  int n_checks;
  int n_errors;

  logic [8:0] exp_q[$];
  int         exp_gnt[$];

  alu_req_scheduler #(
    .DW(4),
    .RW(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver: one command from requester id, rsp_ready assumed 1.
  // Starts on a negedge in IDLE; response expected lat cycles after the
  // handshake cycle, then consumed on the following edge.
  task automatic run_op(input string tag, input int id, input logic [2:0] op,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] exp_res, input logic exp_err, input int lat);
    @(negedge clk);
    if (id == 0) begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    #1;
    check({tag, "_rdy"}, (id == 0) ? req0_ready : req1_ready, 1);
    check({tag, "_rdy_other"}, (id == 0) ? req1_ready : req0_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    // Later input changes must not affect the captured command.
    req0_a = 4'h0; req0_b = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      #1;
      if (k < lat) begin
        check({tag, "_early"}, rsp_valid, 0);
      end else begin
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_id"}, rsp_id, id);
        check({tag, "_result"}, rsp_result, exp_res);
        check({tag, "_err"}, rsp_err, exp_err);
      end
    end
  endtask

  initial begin
    int         n_hs;
    int         n_rsp;
    int         last_hs;
    int         cyc;
    int         g;
    logic [8:0] e;
    logic [7:0] held_res;

    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_op = T_ADD; req0_a = 4'h1; req0_b = 4'h1;
    req1_valid = 1'b1; req1_op = T_ADD; req1_a = 4'h1; req1_b = 4'h1;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_err", rsp_err, 0);
    @(negedge clk);
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;

    // Single ops, latency and results
    run_op("add", 0, T_ADD, 4'd7,  4'd9,  8'h10, 1'b0, 2);
    run_op("sub", 0, T_SUB, 4'd3,  4'd5,  8'hFE, 1'b0, 2);
    run_op("mul", 0, T_MUL, 4'd15, 4'd15, 8'hE1, 1'b0, 2);
    run_op("and", 0, T_AND, 4'hC,  4'hA,  8'h08, 1'b0, 2);
    run_op("or",  0, T_OR,  4'hC,  4'hA,  8'h0E, 1'b0, 2);
    run_op("div13_4", 0, T_DIV, 4'd13, 4'd4, 8'h03, 1'b0, 5);
    run_op("div15_1", 0, T_DIV, 4'd15, 4'd1, 8'h0F, 1'b0, 5);
    run_op("div3_7",  0, T_DIV, 4'd3,  4'd7, 8'h00, 1'b0, 5);
    run_op("div9_0",  0, T_DIV, 4'd9,  4'd0, 8'h00, 1'b1, 2);
    run_op("ill7",    0, T_ILL, 4'd5,  4'd3, 8'h00, 1'b1, 2);
    run_op("r1_sub",  1, T_SUB, 4'd0,  4'd1, 8'hFF, 1'b0, 2);

    // Contention: both valid continuously, grants alternate from 0
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    n_hs = 0; n_rsp = 0; last_hs = 0; cyc = 0;
    @(negedge clk);
    req0_op = T_ADD; req0_a = 4'd1; req0_b = 4'd2; req0_valid = 1'b1;
    req1_op = T_MUL; req1_a = 4'd3; req1_b = 4'd4; req1_valid = 1'b1;
    while ((n_hs < 4 || n_rsp < 4) && cyc < 60) begin
      #1;
      check("cont_onehot", req0_ready & req1_ready, 0);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("cont_unexpected_rsp", rsp_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("cont_rsp_id", rsp_id, e[8]);
          check("cont_rsp_result", rsp_result, e[7:0]);
          check("cont_rsp_err", rsp_err, 0);
          n_rsp++;
        end
      end
      if (req0_ready | req1_ready) begin
        g = req1_ready ? 1 : 0;
        check("cont_grant", g, exp_gnt.pop_front());
        if (n_hs > 0) check("cont_gap", cyc - last_hs, 3);
        exp_q.push_back({g[0], (g == 1) ? 8'h0C : 8'h03});
        n_hs++;
        last_hs = cyc;
        if (n_hs == 4) begin
          @(posedge clk);
          #1;
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      cyc++;
      @(negedge clk);
    end
    check("cont_handshakes", n_hs, 4);
    check("cont_responses", n_rsp, 4);

    // Backpressure: response held 5 cycles with rsp_ready=0
    rsp_ready = 1'b0;
    req0_op = T_MUL; req0_a = 4'd5; req0_b = 4'd6; req0_valid = 1'b1;
    #1;
    check("bp_accept", req0_ready, 1);
    @(posedge clk);
    #1;
    req1_op = T_AND; req1_a = 4'hF; req1_b = 4'h3; req1_valid = 1'b1;
    @(negedge clk);
    #1;
    check("bp_exec_rdy0", req0_ready, 0);
    check("bp_exec_rdy1", req1_ready, 0);
    held_res = 8'h1E;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 0);
      check("bp_result", rsp_result, held_res);
      check("bp_err", rsp_err, 0);
      check("bp_rdy0", req0_ready, 0);
      check("bp_rdy1", req1_ready, 0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_valid", rsp_valid, 1);
    check("bp_hs_result", rsp_result, held_res);
    check("bp_hs_rdy", req0_ready | req1_ready, 0);
    @(negedge clk);
    #1;
    check("bp_resume_valid", rsp_valid, 0);
    check("bp_resume_rdy1", req1_ready, 1);
    check("bp_resume_rdy0", req0_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("bp_r1_valid", rsp_valid, 1);
    check("bp_r1_id", rsp_id, 1);
    check("bp_r1_result", rsp_result, 8'h03);

    // Reset in the second DIV cycle
    @(negedge clk);
    req0_op = T_DIV; req0_a = 4'd13; req0_b = 4'd4; req0_valid = 1'b1;
    #1;
    check("rd_accept", req0_ready, 1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rd_div1_valid", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rd_rsp_valid", rsp_valid, 0);
    check("rd_rsp_id", rsp_id, 0);
    check("rd_rsp_result", rsp_result, 0);
    check("rd_rsp_err", rsp_err, 0);
    check("rd_rdy", req0_ready | req1_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("rd_no_rsp", rsp_valid, 0);
    end
    req0_op = T_ADD; req0_a = 4'd1; req0_b = 4'd2; req0_valid = 1'b1;
    req1_op = T_OR;  req1_a = 4'd5; req1_b = 4'hA; req1_valid = 1'b1;
    #1;
    check("rd_cont_rdy0", req0_ready, 1);
    check("rd_cont_rdy1", req1_ready, 0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rd_post_valid", rsp_valid, 1);
    check("rd_post_id", rsp_id, 0);
    check("rd_post_result", rsp_result, 8'h03);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
